// File: rtl/bn_pingpong_loader.sv
// bn_pingpong_loader
// Input loader for the 16384-point radix-16 memory-based FFT. It accepts one
// point per cycle and pairs each even/odd point into one memory word. The word
// is written to one of the 8 memories of bank BN0 or BN1. The two banks
// alternate frame by frame. The read side sees BN_sel/rd_valid and hands the
// bank back with rd_release.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   din/din_valid   input point and its valid; din_ready = write bank not full
//   mem_wdata/waddr write word and address shared by all 16 memories
//   bn0_wen/bn1_wen per-memory write enables (bit m = MEM m) for each bank
//   BN_sel          bank presented to the read side
//   rd_valid        bank BN_sel holds a complete frame
//   rd_release      read side has finished with bank BN_sel
//   frame_done      one-cycle pulse when a bank has been completely written
//
// Build option: define ADDR_BITREV_EN to write at the bit-reversed address.
// The first stage then reads in digit-reversed order.
module bn_pingpong_loader #(
    parameter int P_WIDTH    = 64,
    parameter int SD_WIDTH   = 128,
    parameter int SEG1       = 64,
    parameter int SEG2       = 128,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [P_WIDTH-1:0]    din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [SD_WIDTH-1:0]   mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            bn0_wen,
    output logic [7:0]            bn1_wen,
    output logic                  BN_sel,
    output logic                  rd_valid,
    input  logic                  rd_release,
    output logic                  frame_done
);
    localparam int KW = ADDR_WIDTH + 4;
    localparam logic [KW-1:0] K_MAX = '1;

    logic [KW-1:0]         k_q, k_d;
    logic [P_WIDTH-1:0]    hold_q, hold_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [1:0]            full_q, full_d;
    logic                  sel_q, sel_d;
    logic                  rdv_q, rdv_d;
    logic                  fd_q, fd_d;
    logic [SD_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wen0_q, wen0_d, wen1_q, wen1_d;
    logic                  accept, last, rel_ok;

    function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
`ifdef ADDR_BITREV_EN
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
`else
        r = a;
`endif
        return r;
    endfunction

    assign din_ready  = ~full_q[wr_bank_q];
    assign mem_wdata  = wdata_q;
    assign mem_waddr  = waddr_q;
    assign bn0_wen    = wen0_q;
    assign bn1_wen    = wen1_q;
    assign BN_sel     = sel_q;
    assign rd_valid   = rdv_q;
    assign frame_done = fd_q;

    always_comb begin
        accept  = din_valid && din_ready;
        last    = accept && (k_q == K_MAX);
        rel_ok  = rd_release && rdv_q;
        k_d     = accept ? k_q + 1'b1 : k_q;   // wraps to 0 after the last point
        hold_d  = (accept && !k_q[0]) ? din : hold_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        wen0_d  = '0;
        wen1_d  = '0;
        if (accept && k_q[0]) begin
            wdata_d[SEG2-1:SEG1] = hold_q;
            wdata_d[SEG1-1:0]    = din;
            waddr_d = map_addr(k_q[KW-1:4]);
            if (wr_bank_q) wen1_d = 8'b1 << k_q[3:1];
            else           wen0_d = 8'b1 << k_q[3:1];
        end

        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        sel_d     = sel_q;
        fd_d      = last;
        if (rel_ok) full_d[sel_q] = 1'b0;
        if (last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d = ~wr_bank_q;
            if (!rdv_q) sel_d = wr_bank_q;
        end
        // Looking at full_d rather than full_q lets a release that coincides
        // with a completing frame move straight on to the newly filled bank.
        if (rel_ok && full_d[!sel_q]) sel_d = ~sel_q;
        rdv_d = full_d[sel_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q       <= '0;
            hold_q    <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            sel_q     <= 1'b0;
            rdv_q     <= 1'b0;
            fd_q      <= 1'b0;
            wdata_q   <= '0;
            waddr_q   <= '0;
            wen0_q    <= '0;
            wen1_q    <= '0;
        end else begin
            k_q       <= k_d;
            hold_q    <= hold_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            sel_q     <= sel_d;
            rdv_q     <= rdv_d;
            fd_q      <= fd_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
            wen0_q    <= wen0_d;
            wen1_q    <= wen1_d;
        end
    end
endmodule

// File: tb/tb_bn_pingpong_loader.sv
module tb_bn_pingpong_loader;
    localparam int FRAME = 16384;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [127:0] mem_wdata;
    logic [9:0]   mem_waddr;
    logic [7:0]   bn0_wen, bn1_wen;
    logic         BN_sel, rd_valid, frame_done;
    logic         rd_release = 1'b0;

    int errors = 0;
    int checks = 0;
    bit go = 0;

    bn_pingpong_loader dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .bn0_wen(bn0_wen), .bn1_wen(bn1_wen),
        .BN_sel(BN_sel), .rd_valid(rd_valid), .rd_release(rd_release), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_k;
    logic [63:0] m_hold;
    int          m_wr, m_sel;
    bit          m_full [2];
    logic [127:0] e_wdata;
    logic [9:0]  e_waddr;
    logic [7:0]  e_wen0, e_wen1;
    logic        e_rdv, e_fd;

    function automatic logic [9:0] addr_of(input int k);
        logic [9:0] a, r;
        a = 10'(k / 16);
`ifdef ADDR_BITREV_EN
        for (int i = 0; i < 10; i++) r[i] = a[9-i];
`else
        r = a;
`endif
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_k = 0; m_hold = '0; m_wr = 0; m_sel = 0;
                m_full[0] = 0; m_full[1] = 0;
                e_wdata = '0; e_waddr = '0; e_wen0 = '0; e_wen1 = '0;
                e_rdv = 0; e_fd = 0;
            end else begin
                bit acc, lst, rel;
                int old;
                acc = din_valid && !m_full[m_wr];
                rel = rd_release && e_rdv;
                lst = 0;
                e_wen0 = '0; e_wen1 = '0; e_fd = 0;
                if (acc) begin
                    if (m_k % 2 == 0) m_hold = din;
                    else begin
                        e_wdata = {m_hold, din};
                        e_waddr = addr_of(m_k);
                        if (m_wr == 1) e_wen1 = 8'(1 << ((m_k / 2) % 8));
                        else           e_wen0 = 8'(1 << ((m_k / 2) % 8));
                    end
                    lst = (m_k == FRAME - 1);
                    m_k = (m_k + 1) % FRAME;
                end
                if (rel) m_full[m_sel] = 0;
                if (lst) begin
                    old = m_wr;
                    m_full[m_wr] = 1;
                    m_wr = 1 - m_wr;
                    e_fd = 1;
                    if (!e_rdv) m_sel = old;
                end
                if (rel && m_full[1 - m_sel]) m_sel = 1 - m_sel;
                e_rdv = m_full[m_sel];
            end
        end
    end

    // One comparison of the whole output vector per cycle.
    always @(negedge clk) begin
        if (go)
            chk("cycle", {7'd0, din_ready, mem_wdata, mem_waddr, bn0_wen, bn1_wen, BN_sel, rd_valid, frame_done},
                {7'd0, !m_full[m_wr], e_wdata, e_waddr, e_wen0, e_wen1, m_sel[0], e_rdv, e_fd});
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [63:0] d, input logic rel, input logic r);
        rst = r; din_valid = v; din = d; rd_release = rel;
        @(posedge clk); #2;
        rst = 1'b0; din_valid = 1'b0; rd_release = 1'b0;
    endtask

    task automatic stream(input int first, input int lastk);
        for (int i = first; i <= lastk; i++) cyc(1'b1, 64'(i), 1'b0, 1'b0);
    endtask

    initial begin
        logic [9:0] exp_a1;
`ifdef ADDR_BITREV_EN
        exp_a1 = 10'd512;
`else
        exp_a1 = 10'd1;
`endif
        cyc(1'b0, '0, 1'b0, 1'b1);
        go = 1;
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("reset_ready", din_ready, 1);
        chk("reset_outs", {mem_wdata, mem_waddr, bn0_wen, bn1_wen, BN_sel, rd_valid, frame_done}, '0);

        // first frame row: bn0_wen walks across the 8 memories
        cyc(1'b1, 64'd0, 1'b0, 1'b0);
        chk("even_no_write", bn0_wen, 8'h00);
        cyc(1'b1, 64'd1, 1'b0, 1'b0);
        chk("first_word", mem_wdata, {64'd0, 64'd1});
        chk("first_wen", {bn0_wen, bn1_wen, mem_waddr}, {8'h01, 8'h00, 10'd0});
        stream(2, 14);
        cyc(1'b1, 64'd15, 1'b0, 1'b0);
        chk("row0_last_word", mem_wdata, {64'd14, 64'd15});
        chk("row0_last_wen", {bn0_wen, mem_waddr}, {8'h80, 10'd0});

        // gap mid-pair keeps the held point
        cyc(1'b1, 64'd16, 1'b0, 1'b0);
        cyc(1'b0, 64'hFFFF, 1'b0, 1'b0);
        chk("gap_no_write", {bn0_wen, bn1_wen}, 16'h0);
        cyc(1'b1, 64'd17, 1'b0, 1'b0);
        chk("gap_word", mem_wdata, {64'd16, 64'd17});
        chk("row1_addr", {bn0_wen, mem_waddr}, {8'h01, exp_a1});

        // finish bank 0
        stream(18, FRAME - 2);
        cyc(1'b1, 64'(FRAME - 1), 1'b0, 1'b0);
        chk("frame0_done", {frame_done, BN_sel, rd_valid, din_ready, bn0_wen}, {4'b1011, 8'h80});
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("frame0_pulse_end", frame_done, 0);

        // fill bank 1 without release
        stream(FRAME, 2 * FRAME - 2);
        cyc(1'b1, 64'(2 * FRAME - 1), 1'b0, 1'b0);
        chk("frame1_done", {frame_done, BN_sel, rd_valid, din_ready, bn1_wen, bn0_wen}, {4'b1010, 8'h80, 8'h00});
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'hDEAD, 1'b0, 1'b0);
        chk("stall", {din_ready, bn0_wen, bn1_wen}, 17'h0);

        // release with both banks full
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("release_switch", {BN_sel, rd_valid, din_ready}, 3'b111);
        cyc(1'b1, 64'd100, 1'b0, 1'b0);
        cyc(1'b1, 64'd101, 1'b0, 1'b0);
        chk("after_release_word", mem_wdata, {64'd100, 64'd101});
        chk("after_release_wen", {bn0_wen, bn1_wen, mem_waddr}, {8'h01, 8'h00, 10'd0});

        // release coinciding with last point of the frame
        stream(2, FRAME - 2);
        cyc(1'b1, 64'(FRAME - 1), 1'b1, 1'b0);
        chk("release_on_last", {frame_done, BN_sel, rd_valid, din_ready}, 4'b1011);

        // reset mid-pair
        stream(0, 6);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("midreset_outs", {mem_wdata, mem_waddr, bn0_wen, bn1_wen, BN_sel, rd_valid, frame_done}, '0);
        chk("midreset_ready", din_ready, 1);
        cyc(1'b1, 64'hA5, 1'b0, 1'b0);
        chk("midreset_even", {bn0_wen, bn1_wen}, 16'h0);
        cyc(1'b1, 64'h5A, 1'b0, 1'b0);
        chk("midreset_word", mem_wdata, {64'hA5, 64'h5A});
        chk("midreset_wen", {bn0_wen, bn1_wen, mem_waddr}, {8'h01, 8'h00, 10'd0});

        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        go = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
